// File: rtl/reduction_mask_bank.sv
// Per-channel bit-reduction mask bank. Config edits go to shadow keep counts and
// reach the active masks only on frame_start. Pixels are ANDed with the active masks in two stages.
module reduction_mask_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 2,
    parameter int KW       = 4,
    parameter logic [CHANNELS*KW-1:0] DEFAULT_KEEP = {4'd2, 4'd2, 4'd3}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [1:0]                cfg_op,
    input  logic [KW-1:0]             cfg_keep,
    output logic                      cfg_err,
    input  logic                      frame_start,
    output logic                      pending,
    input  logic                      pix_valid_in,
    input  logic [CHANNELS*WIDTH-1:0] pix_in,
    output logic                      pix_valid_out,
    output logic [CHANNELS*WIDTH-1:0] pix_out,
    output logic [CHANNELS*WIDTH-1:0] mask_out
);
    localparam int PW = CHANNELS * WIDTH;
    localparam logic [KW-1:0] KEEP_MAX = KW'(WIDTH);

    logic [CHANNELS*KW-1:0] shadow_q, shadow_d, active_q, active_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic                   pending_q, pending_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [PW-1:0]          s1_pix_q, s1_pix_d;
    logic [PW-1:0]          s1_mask_q, s1_mask_d;
    logic                   out_valid_q, out_valid_d;
    logic [PW-1:0]          out_pix_q, out_pix_d;
    logic                   accept, sel_bad;
    logic [KW-1:0]          cur_keep, def_keep, new_keep;

    // Top 'keep' bits set: bit b is kept when b >= WIDTH - keep.
    function automatic logic [WIDTH-1:0] keep_to_mask(input logic [KW-1:0] keep);
        logic [WIDTH-1:0] m;
        for (int b = 0; b < WIDTH; b++) begin
            m[b] = ((int'(keep) + b) >= WIDTH);
        end
        return m;
    endfunction

    always_comb begin
        mask_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mask_out[c*WIDTH +: WIDTH] = keep_to_mask(active_q[c*KW +: KW]);
        end
    end

    assign cfg_ready     = ready_q & ~frame_start;
    assign accept        = cfg_valid & cfg_ready;
    assign sel_bad       = (int'(cfg_sel) >= CHANNELS);
    assign cfg_err       = err_q;
    assign pending       = pending_q;
    assign pix_valid_out = out_valid_q;
    assign pix_out       = out_pix_q;

    always_comb begin
        cur_keep = '0;
        def_keep = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(cfg_sel) == c) begin
                cur_keep = shadow_q[c*KW +: KW];
                def_keep = DEFAULT_KEEP[c*KW +: KW];
            end
        end
        case (cfg_op)
            2'b00:   new_keep = (cfg_keep > KEEP_MAX) ? KEEP_MAX : cfg_keep;
            2'b01:   new_keep = (cur_keep >= KEEP_MAX) ? KEEP_MAX : cur_keep + KW'(1);
            2'b10:   new_keep = (cur_keep == '0) ? '0 : cur_keep - KW'(1);
            default: new_keep = def_keep;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        // frame_start blocks acceptance, so a commit never races a shadow edit.
        if (frame_start) begin
            active_d = shadow_q;
        end
        if (accept && !sel_bad) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(cfg_sel) == c) begin
                    shadow_d[c*KW +: KW] = new_keep;
                end
            end
        end
        err_d     = err_q | (accept & sel_bad);
        ready_d   = 1'b1;
        pending_d = (shadow_d != active_d);

        s1_valid_d  = pix_valid_in;
        s1_pix_d    = pix_in;
        s1_mask_d   = mask_out;
        out_valid_d = s1_valid_q;
        out_pix_d   = s1_valid_q ? (s1_pix_q & s1_mask_q) : out_pix_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q    <= DEFAULT_KEEP;
            active_q    <= DEFAULT_KEEP;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            pending_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_mask_q   <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            pending_q   <= pending_d;
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_mask_q   <= s1_mask_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
        end
    end
endmodule

// File: tb/tb_reduction_mask_bank.sv
// Bench for reduction_mask_bank: directed scenarios plus random traffic, all
// checked every cycle against a keep-count / pixel-queue model.
module tb_reduction_mask_bank;
    logic        clk = 1'b0;
    logic        reset_n, cfg_valid, cfg_ready, cfg_err, frame_start, pending;
    logic        pix_valid_in, pix_valid_out;
    logic [1:0]  cfg_sel, cfg_op;
    logic [3:0]  cfg_keep;
    logic [23:0] pix_in, pix_out, mask_out;

    always #5 clk = ~clk;

    reduction_mask_bank dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_op(cfg_op), .cfg_keep(cfg_keep), .cfg_err(cfg_err),
        .frame_start(frame_start), .pending(pending), .pix_valid_in(pix_valid_in),
        .pix_in(pix_in), .pix_valid_out(pix_valid_out), .pix_out(pix_out), .mask_out(mask_out)
    );

    typedef struct packed {logic v; logic [23:0] p;} pix_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    check_en = 0;
    int    m_shadow[3];
    int    m_active[3];
    int    def_keep[3] = '{3, 2, 2};
    bit    m_ready, m_err, m_out_valid;
    logic [23:0] m_out_pix;
    pix_t  m_q[$];

    function automatic logic [23:0] mmask(input int k);
        return 24'((32'hFF << (8 - k)) & 32'hFF);
    endfunction

    function automatic logic [23:0] mmasks();
        return mmask(m_active[0]) | (mmask(m_active[1]) << 8) | (mmask(m_active[2]) << 16);
    endfunction

    function automatic bit m_pending();
        for (int i = 0; i < 3; i++) if (m_shadow[i] != m_active[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        pix_t e;
        int k;
        bit acc;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] = def_keep[i];
                m_active[i] = def_keep[i];
            end
            m_err = 0; m_ready = 0; m_out_valid = 0; m_out_pix = '0;
            m_q.delete();
            return;
        end
        e.v = pix_valid_in;
        e.p = pix_in & mmasks();
        m_q.push_back(e);
        if (m_q.size() > 1) begin
            e = m_q.pop_front();
            m_out_valid = e.v;
            if (e.v) m_out_pix = e.p;
        end
        acc = cfg_valid && m_ready && !frame_start;
        if (frame_start) m_active = m_shadow;
        if (acc) begin
            if (int'(cfg_sel) >= 3) m_err = 1;
            else begin
                k = m_shadow[cfg_sel];
                case (cfg_op)
                    2'd0: k = (int'(cfg_keep) > 8) ? 8 : int'(cfg_keep);
                    2'd1: k = (k < 8) ? k + 1 : 8;
                    2'd2: k = (k > 0) ? k - 1 : 0;
                    default: k = def_keep[cfg_sel];
                endcase
                m_shadow[cfg_sel] = k;
            end
        end
        m_ready = 1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready && !frame_start));
            chk("pending", 32'(pending), 32'(m_pending()));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            chk("mask_out", 32'(mask_out), 32'(mmasks()));
            chk("pix_valid_out", 32'(pix_valid_out), 32'(m_out_valid));
            chk("pix_out", 32'(pix_out), 32'(m_out_pix));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [1:0] op, input logic [3:0] keep);
        cfg_valid = 1; cfg_sel = sel; cfg_op = op; cfg_keep = keep;
        cycle();
        cfg_valid = 0;
    endtask

    task automatic commit();
        frame_start = 1;
        cycle();
        frame_start = 0;
    endtask

    initial begin
        reset_n = 0; cfg_valid = 0; cfg_sel = 0; cfg_op = 0; cfg_keep = 0;
        frame_start = 0; pix_valid_in = 0; pix_in = '0;
        cycle();
        check_en = 1;
        cycle(); cycle();
        reset_n = 1;
        cycle();
        chk("lit_reset_mask", 32'(mask_out), 32'h00C0C0E0);
        chk("lit_ready_after_reset", 32'(cfg_ready), 32'd1);

        pix_valid_in = 1; pix_in = 24'hFFFFFF;
        cycle();
        pix_valid_in = 0; pix_in = '0;
        chk("lit_latency_not_1", 32'(pix_valid_out), 32'd0);
        cycle();
        chk("lit_latency_2_valid", 32'(pix_valid_out), 32'd1);
        chk("lit_default_pix", 32'(pix_out), 32'h00C0C0E0);
        cycle();

        cfg(2'd2, 2'd0, 4'd5);
        chk("lit_pending_set", 32'(pending), 32'd1);
        chk("lit_mask_before_commit", 32'(mask_out), 32'h00C0C0E0);
        commit();
        chk("lit_ch2_F8", 32'(mask_out[23:16]), 32'h000000F8);
        chk("lit_pending_clear", 32'(pending), 32'd0);

        for (int i = 0; i < 10; i++) cfg(2'd1, 2'd1, 4'd0);
        for (int i = 0; i < 5; i++) cfg(2'd0, 2'd2, 4'd0);
        commit();
        chk("lit_sat_masks", 32'(mask_out), 32'h00F8FF00);

        cfg(2'd0, 2'd0, 4'd15);
        commit();
        chk("lit_clamp_ch0", 32'(mask_out), 32'h00F8FFFF);
        chk("lit_err_clear", 32'(cfg_err), 32'd0);
        cfg(2'd3, 2'd0, 4'd1);
        chk("lit_err_set", 32'(cfg_err), 32'd1);
        chk("lit_bad_sel_nochange", 32'(mask_out), 32'h00F8FFFF);

        cfg_valid = 1; cfg_sel = 2'd2; cfg_op = 2'd2; frame_start = 1;
        #1;
        chk("lit_ready_low_on_fs", 32'(cfg_ready), 32'd0);
        cycle();
        frame_start = 0;
        #1;
        chk("lit_ready_back", 32'(cfg_ready), 32'd1);
        cycle();
        cfg_valid = 0;
        chk("lit_held_pending", 32'(pending), 32'd1);
        chk("lit_held_not_committed", 32'(mask_out[23:16]), 32'h000000F8);
        commit();
        chk("lit_held_commit", 32'(mask_out[23:16]), 32'h000000F0);

        // Stream 0xFFFFFF; ch1 goes 8 -> 1 on the commit at i==5.
        for (int i = 0; i < 12; i++) begin
            pix_valid_in = 1; pix_in = 24'hFFFFFF;
            frame_start = (i == 5);
            if (i == 3) begin cfg_valid = 1; cfg_sel = 2'd1; cfg_op = 2'd0; cfg_keep = 4'd1; end
            cycle();
            cfg_valid = 0;
            if (i == 6) chk("lit_inflight_old", 32'(pix_out[15:8]), 32'h000000FF);
            if (i == 7) chk("lit_after_commit_new", 32'(pix_out[15:8]), 32'h00000080);
        end
        frame_start = 0;
        reset_n = 0;
        cycle();
        chk("lit_reset_valid", 32'(pix_valid_out), 32'd0);
        chk("lit_reset_masks", 32'(mask_out), 32'h00C0C0E0);
        reset_n = 1;
        cycle(); cycle(); cycle();
        pix_valid_in = 0;

        for (int i = 0; i < 600; i++) begin
            reset_n      = ($urandom_range(0, 149) != 0);
            cfg_valid    = 1'($urandom_range(0, 1));
            cfg_sel      = ($urandom_range(0, 24) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cfg_op       = 2'($urandom_range(0, 3));
            cfg_keep     = 4'($urandom_range(0, 15));
            frame_start  = ($urandom_range(0, 7) == 0);
            pix_valid_in = ($urandom_range(0, 3) != 0);
            pix_in       = 24'($urandom);
            cycle();
        end
        reset_n = 1; cfg_valid = 0; frame_start = 0; pix_valid_in = 0;
        cycle(); cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
